digit_scan_ctrl: RTL

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

---
 rtl/digit_scan_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/digit_scan_ctrl.sv
// Multiplexed common-anode digit scanner: double-buffered digit codes/blanks,
// ascending slot scan and per-slot PWM brightness, all outputs registered.
module digit_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int TICK_DIV   = 262144,
    parameter int BRIGHT_W   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]         blank_in,
    input  logic                          load,
    input  logic [BRIGHT_W-1:0]           brightness,
    output logic [DIGIT_W-1:0]            muxd,
    output logic [NUM_DIGITS-1:0]         adrive,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic                          pending,
    output logic                          frame_start
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] L_STEP    = CNT_W'(TICK_DIV / (2 ** BRIGHT_W));
    localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]                      r_cnt;
    logic [SEL_W-1:0]                      r_slot;
    logic [BRIGHT_W-1:0]                   r_bright;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    r_shd_code;
    logic [NUM_DIGITS-1:0]                 r_shd_blank;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    r_act_code;
    logic [NUM_DIGITS-1:0]                 r_act_blank;
    logic                                  r_pending;
    logic [DIGIT_W-1:0]                    r_muxd;
    logic [NUM_DIGITS-1:0]                 r_adrive;
    logic [SEL_W-1:0]                      r_digit_sel;
    logic                                  r_frame_d1;
    logic                                  r_frame_start;

    logic                                  w_slot_end;
    logic                                  w_frame_bnd;
    logic [CNT_W-1:0]                      w_on_limit;
    logic [DIGIT_W-1:0]                    w_cur_code;
    logic                                  w_cur_blank;
    logic                                  w_lit;
    logic [NUM_DIGITS-1:0]                 w_sel_onehot;

    assign w_slot_end   = (r_cnt == CNT_LAST);
    assign w_frame_bnd  = w_slot_end && (r_slot == SLOT_LAST);
    assign w_on_limit   = CNT_W'(r_bright) * L_STEP;
    assign w_cur_code   = r_act_code[r_slot];
    assign w_cur_blank  = r_act_blank[r_slot];
    assign w_lit        = (r_cnt < w_on_limit) && !w_cur_blank;
    assign w_sel_onehot = NUM_DIGITS'(1) << r_slot;

    // Prescaler and slot index; brightness is latched on the edge that opens
    // the next slot so the duty level is stable for the whole slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_slot   <= '0;
            r_bright <= '0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + CNT_W'(1);
            if (w_slot_end) begin
                r_slot   <= (r_slot == SLOT_LAST) ? '0 : r_slot + SEL_W'(1);
                r_bright <= brightness;
            end
        end
    end

    // NOTE: the digit buffers are a handful of flops rather than a RAM, so they
    // take the async reset; blanks reset to ones so nothing lights before a load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shd_code  <= '0;
            r_shd_blank <= '1;
            r_act_code  <= '0;
            r_act_blank <= '1;
            r_pending   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let a load on the boundary edge land in
            // the shadow while the active buffer still copies the pre-load shadow.
            if (load) begin
                r_shd_code  <= data_in;
                r_shd_blank <= blank_in;
            end
            if (w_frame_bnd && r_pending) begin
                r_act_code  <= r_shd_code;
                r_act_blank <= r_shd_blank;
            end
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_frame_bnd) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Output stage: one clock behind the scan state; frame_start needs two
    // stages so it lines up with the first digit_sel==0 of the new frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_muxd        <= '0;
            r_adrive      <= '1;
            r_digit_sel   <= '0;
            r_frame_d1    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_muxd        <= w_cur_code;
            r_adrive      <= w_lit ? ~w_sel_onehot : '1;
            r_digit_sel   <= r_slot;
            r_frame_d1    <= w_frame_bnd;
            r_frame_start <= r_frame_d1;
        end
    end

    assign muxd        = r_muxd;
    assign adrive      = r_adrive;
    assign digit_sel   = r_digit_sel;
    assign pending     = r_pending;
    assign frame_start = r_frame_start;

endmodule
